// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory arbiter.
//   state_t    : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   WORD_BYTES : bytes per memory word
//   word_legal : 1 when a word access is aligned and fully inside memory
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 32'd4;

  // The range test is a plain compare against the last word address, so
  // addresses near the top of the 32-bit space can never wrap into low memory.
  function automatic logic word_legal(input logic [31:0] addr, input logic [31:0] mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= (mem_bytes - WORD_BYTES));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector, one bit per requester
//   ptr : index with highest priority this round
//   gnt : one-hot grant, zero when no request is pending
module rr_arbiter
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
)
(
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic w_found;

  // Walk offsets 0..N-1 from ptr; the first pending requester wins.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && req[i] && (i == ((int'(ptr) + k) % N))) begin
          gnt[i]  = 1'b1;
          w_found = 1'b1;
        end else begin
          w_found = w_found;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port word memory.
//   req_valid/req_we/req_addr/req_wdata : per-requester request (32-bit slices)
//   req_ready                           : one-hot accept, combinational in IDLE
//   resp_valid/resp_err/resp_rdata      : one-cycle response to the winner
//   mem_address/mem_data/mem_*_enable   : registered memory drive
//   mem_out                             : memory read data
//   busy                                : a transaction is in flight
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter int unsigned MEM_BYTES = 32'd4096
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_we,
  input  logic [N_REQ*32-1:0]  req_addr,
  input  logic [N_REQ*32-1:0]  req_wdata,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic                 resp_err,
  output logic [31:0]          resp_rdata,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_data,
  output logic                 mem_read_enable,
  output logic                 mem_write_enable,
  input  logic [31:0]          mem_out,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_w;
  logic              r_we;
  logic              r_legal;
  logic              r_rd_ok;
  logic [N_REQ-1:0]  r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_mem_address;
  logic [31:0]       r_mem_data;
  logic              r_mem_re;
  logic              r_mem_we;

  logic [N_REQ-1:0]  w_gnt;
  logic [PW-1:0]     w_win;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_legal;
  logic [PW-1:0]     w_next_ptr;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  // Select the winner's index and payload from the one-hot grant.
  always_comb begin
    w_win   = '0;
    w_we    = 1'b0;
    w_addr  = 32'h0000_0000;
    w_wdata = 32'h0000_0000;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win   = PW'(i);
        w_we    = req_we[i];
        w_addr  = req_addr[32*i +: 32];
        w_wdata = req_wdata[32*i +: 32];
      end else begin
        w_win   = w_win;
      end
    end
  end

  assign w_legal = word_legal(w_addr, MEM_BYTES);

  // Pointer advances to the requester after the winner, wrapping at N_REQ.
  always_comb begin
    if (w_win == PW'(N_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_win + PW'(1);
    end
  end

  // Sequencer: accept in IDLE, drive memory in ACCESS, respond in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_w           <= '0;
      r_we          <= 1'b0;
      r_legal       <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_resp_valid  <= '0;
      r_resp_err    <= 1'b0;
      r_mem_address <= 32'h0000_0000;
      r_mem_data    <= 32'h0000_0000;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= '0;
          r_resp_err   <= 1'b0;
          r_rd_ok      <= 1'b0;
          if (|req_valid) begin
            r_w           <= w_win;
            r_we          <= w_we;
            r_legal       <= w_legal;
            r_mem_address <= w_addr;
            r_mem_data    <= w_wdata;
            // Only the latched direction is enabled, and never for an illegal access.
            r_mem_re      <= w_legal & ~w_we;
            r_mem_we      <= w_legal & w_we;
            r_ptr         <= w_next_ptr;
            r_state       <= ACCESS;
          end else begin
            r_state       <= IDLE;
          end
        end
        ACCESS: begin
          r_mem_re     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_resp_valid <= ONE_HOT0 << r_w;
          r_resp_err   <= ~r_legal;
          r_rd_ok      <= r_legal & ~r_we;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= '0;
          r_resp_err   <= 1'b0;
          r_rd_ok      <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_mem_re     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_resp_valid <= '0;
          r_resp_err   <= 1'b0;
          r_rd_ok      <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready        = (r_state == IDLE) ? w_gnt : '0;
  assign resp_valid       = r_resp_valid;
  assign resp_err         = r_resp_err;
  // Memory output is only valid in the cycle after the read edge, so it is gated, not registered.
  assign resp_rdata       = r_rd_ok ? mem_out : 32'h0000_0000;
  assign mem_address      = r_mem_address;
  assign mem_data         = r_mem_data;
  assign mem_read_enable  = r_mem_re;
  assign mem_write_enable = r_mem_we;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model
// and a behavioural memory device.
module tb_mem_arbiter;

  localparam int N  = 2;
  localparam int MB = 4096;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_we;
  logic [N*32-1:0]   req_addr;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [31:0]       mem_address;
  logic [31:0]       mem_data;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [31:0]       mem_out;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] sim_mem [MB];
  logic [7:0] ref_mem [MB];
  int re_count = 0;
  int we_count = 0;

  int glog_who[$];
  int glog_cyc[$];

  mem_arbiter #(.N_REQ(N), .MEM_BYTES(MB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_out          (mem_out),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 7 + 3) % 256);
  endfunction

  function automatic logic [31:0] sim_word(input int a);
    return {sim_mem[a], sim_mem[a+1], sim_mem[a+2], sim_mem[a+3]};
  endfunction

  // Memory device: big-endian words, operation at the rising edge.
  initial begin
    int a;
    for (int k = 0; k < MB; k++) sim_mem[k] = init_byte(k);
    mem_out = 32'h0;
    forever begin
      @(posedge clk);
      a = int'(mem_address);
      if (mem_write_enable) begin
        we_count++;
        if (a >= 0 && a + 3 < MB) begin
          sim_mem[a]   = mem_data[31:24];
          sim_mem[a+1] = mem_data[23:16];
          sim_mem[a+2] = mem_data[15:8];
          sim_mem[a+3] = mem_data[7:0];
        end
      end
      if (mem_read_enable) begin
        re_count++;
        if (a >= 0 && a + 3 < MB) mem_out = sim_word(a);
        else mem_out = 32'hxxxx_xxxx;
      end
    end
  end

  // Reference model: a transaction is accepted, then 1 cycle of memory
  // access, then 1 cycle of response; grants rotate from the last winner.
  initial begin
    int phase, ptr, who, idx;
    logic m_we, m_ok;
    logic [31:0] m_addr, m_wdata, exp_rd;
    logic [N-1:0] exp_rdy;
    longint ua;
    for (int k = 0; k < MB; k++) ref_mem[k] = init_byte(k);
    phase = 0; ptr = 0; who = 0; m_we = 1'b0; m_ok = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) begin glog_who.push_back(i); glog_cyc.push_back(cyc); end
      end
      if (!rst_n) begin
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_mem_re", 32'(mem_read_enable), 32'h0);
        chk("rst_mem_we", 32'(mem_write_enable), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        phase = 0; ptr = 0;
      end else if (phase == 0) begin
        exp_rdy = '0;
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (exp_rdy == '0 && req_valid[idx]) begin exp_rdy[idx] = 1'b1; who = idx; end
        end
        chk("idle_req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_resp_valid", 32'(resp_valid), 32'h0);
        chk("idle_enables", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        if (exp_rdy != '0) begin
          m_we    = req_we[who];
          m_addr  = req_addr[32*who +: 32];
          m_wdata = req_wdata[32*who +: 32];
          ua      = longint'(m_addr);
          m_ok    = (ua % 4 == 0) && (ua + 4 <= MB);
          ptr     = (who + 1) % N;
          phase   = 1;
        end
      end else if (phase == 1) begin
        chk("acc_busy", 32'(busy), 32'h1);
        chk("acc_req_ready", 32'(req_ready), 32'h0);
        chk("acc_resp_valid", 32'(resp_valid), 32'h0);
        chk("acc_read_enable", 32'(mem_read_enable), 32'(m_ok && !m_we));
        chk("acc_write_enable", 32'(mem_write_enable), 32'(m_ok && m_we));
        if (m_ok) chk("acc_address", mem_address, m_addr);
        if (m_ok && m_we) begin
          chk("acc_data", mem_data, m_wdata);
          for (int b = 0; b < 4; b++) ref_mem[int'(m_addr) + b] = m_wdata[31 - 8*b -: 8];
        end
        phase = 2;
      end else begin
        exp_rd = 32'h0;
        if (m_ok && !m_we)
          for (int b = 0; b < 4; b++) exp_rd = {exp_rd[23:0], ref_mem[int'(m_addr) + b]};
        chk("rsp_busy", 32'(busy), 32'h1);
        chk("rsp_req_ready", 32'(req_ready), 32'h0);
        chk("rsp_enables", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        chk("rsp_valid", 32'(resp_valid), 32'(1 << who));
        chk("rsp_err", 32'(resp_err), 32'(!m_ok));
        chk("rsp_rdata", resp_rdata, exp_rd);
        phase = 0;
      end
    end
  end

  // Present a request and hold it until accepted; returns 1 ns after the accept edge.
  task automatic issue(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    req_we[i] = we;
    req_addr[32*i +: 32]  = addr;
    req_wdata[32*i +: 32] = wd;
    req_valid[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 50);
    if (!req_ready[i]) timeout_fail("accept_timeout");
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Wait for the response to requester i; lat counts cycles from acceptance.
  task automatic wait_resp(input int i, output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[i] && n < 20);
    if (!resp_valid[i]) timeout_fail("resp_timeout");
    rd  = resp_rdata;
    er  = resp_err;
    lat = n;
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int target);
    int n;
    n = 0;
    while (glog_who.size() < target && n < 100) begin @(posedge clk); n++; end
    if (glog_who.size() < target) timeout_fail("grant_timeout");
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, re0, we0;
    int exp_who[5] = '{0, 1, 0, 1, 0};

    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read of address 0
    issue(0, 1'b0, 32'd0, 32'h0);
    wait_resp(0, rd, er, lat);
    chk("read0_latency", 32'(lat), 32'd2);
    chk("read0_rdata", rd, 32'h030a1118);
    chk("read0_err", 32'(er), 32'h0);

    // Write then read by requester 1
    issue(1, 1'b1, 32'd8, 32'hffbb00aa);
    wait_resp(1, rd, er, lat);
    chk("write8_err", 32'(er), 32'h0);
    chk("write8_rdata", rd, 32'h0);
    issue(1, 1'b0, 32'd8, 32'h0);
    wait_resp(1, rd, er, lat);
    chk("read8_rdata", rd, 32'hffbb00aa);

    // Fairness: both hold valid; pointer is back at 0 here
    glog_who.delete(); glog_cyc.delete();
    req_we = '0;
    req_addr  = {32'd4, 32'd0};
    req_valid = 2'b11;
    wait_grants(4);
    req_valid[1] = 1'b0;
    wait_grants(5);
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("fair_count", 32'(glog_who.size()), 32'd5);
    for (int k = 0; k < 5 && k < glog_who.size(); k++) chk("fair_who", 32'(glog_who[k]), 32'(exp_who[k]));
    for (int k = 0; k + 1 < glog_cyc.size(); k++) chk("fair_spacing", 32'(glog_cyc[k+1] - glog_cyc[k]), 32'd3);
    if (glog_cyc.size() >= 4) chk("fair_period", 32'(glog_cyc[3] - glog_cyc[1]), 32'd6);

    // Error cases and the top legal word
    re0 = re_count;
    issue(0, 1'b0, 32'd4093, 32'h0);
    wait_resp(0, rd, er, lat);
    chk("err4093_err", 32'(er), 32'h1);
    chk("err4093_rdata", rd, 32'h0);
    chk("err4093_no_read", 32'(re_count), 32'(re0));
    we0 = we_count;
    issue(1, 1'b1, 32'd6, 32'h12345678);
    wait_resp(1, rd, er, lat);
    chk("err6_err", 32'(er), 32'h1);
    chk("err6_no_write", 32'(we_count), 32'(we0));
    chk("err6_mem4", sim_word(4), 32'h1f262d34);
    chk("err6_mem8", sim_word(8), 32'hffbb00aa);
    issue(0, 1'b0, 32'd4092, 32'h0);
    wait_resp(0, rd, er, lat);
    chk("read4092_err", 32'(er), 32'h0);
    chk("read4092_rdata", rd, 32'he7eef5fc);

    // Reset during the ACCESS cycle of a write
    issue(0, 1'b1, 32'd16, 32'hdeadbeef);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_write_enable", 32'(mem_write_enable), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_address", mem_address, 32'h0);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rstmid_mem16", sim_word(16), 32'h737a8188);
    issue(0, 1'b0, 32'd16, 32'h0);
    wait_resp(0, rd, er, lat);
    chk("rstmid_read16", rd, 32'h737a8188);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
